imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 The block SHALL have the parameter `word_size`, default 32: address and instruction width in bits.
REQ-002 The block SHALL have the parameter `RESET_PC`, default 32'h0000_0000: first fetch address after reset (word-aligned).
REQ-003 The block SHALL have the parameter `BUF_DEPTH`, default 2: fetch buffer entries (legal values 2 or 4).
REQ-004 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port `rst_n`, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have the port `imem_addr`, output, word_size bits: byte address to the combinational instruction memory.
REQ-007 The block SHALL have the port `imem_rd_instr`, input, word_size bits: instruction word returned for `imem_addr` in the same cycle.
REQ-008 The block SHALL have the port `redirect_valid`, input, 1 bit: branch/jump redirect request.
REQ-009 The block SHALL have the port `redirect_pc`, input, word_size bits: redirect target byte address.
REQ-010 The block SHALL have the port `instr_valid`, output, 1 bit: the buffer head holds a valid instruction.
REQ-011 The block SHALL have the port `instr_ready`, input, 1 bit: decode accepts the head entry this cycle.
REQ-012 The block SHALL have the port `instr_out`, output, word_size bits: head instruction.
REQ-013 The block SHALL have the port `instr_pc`, output, word_size bits: byte address of the head instruction.
REQ-014 The block SHALL have the port `fetch_trap`, output, 1 bit: misaligned-redirect trap (FETCH_ALIGN_CHK_EN only; tied 0 otherwise).

Function
REQ-015 The block SHALL implement the FSM states IDLE, FETCH and TRAP; TRAP SHALL exist only with FETCH_ALIGN_CHK_EN.
REQ-016 IDLE SHALL be entered on reset and last exactly one cycle after `rst_n` deasserts, with no push; IDLE SHALL then go to FETCH unconditionally.
REQ-017 `imem_addr` SHALL equal the PC register at all times.
REQ-018 In FETCH, push: if the buffer is not full, or a pop occurs this cycle, then {`imem_rd_instr`, PC} SHALL be written to the buffer tail and PC SHALL become PC+4.
REQ-019 Pop: `instr_valid` AND `instr_ready` SHALL remove the head entry; pop and push in the same cycle SHALL be legal when full, keeping the count constant.
REQ-020 `instr_valid` SHALL be 1 exactly when the count is greater than 0; `instr_out`/`instr_pc` SHALL be the head fields, and are don't-care when the buffer is empty.
REQ-021 Throughput: with `instr_ready` held at 1 and no redirect, the block SHALL deliver one instruction per cycle starting 2 cycles after reset release.
REQ-022 Redirect: `redirect_valid`=1 SHALL take priority over push and pop.
REQ-023 On redirect the buffer SHALL be flushed (count set to 0), PC SHALL be set to `redirect_pc`, and no entry SHALL be pushed or popped in that cycle.
REQ-024 After a redirect, `instr_valid` SHALL be 0 in the next cycle and the target instruction SHALL appear at the head one cycle later.
REQ-025 Back-to-back redirects SHALL each flush; the last one SHALL win.
REQ-026 Wrap-around: PC+4 SHALL wrap modulo 2^word_size (32'hFFFF_FFFC → 32'h0000_0000), with no flag.
REQ-027 Buffer pointers SHALL wrap modulo BUF_DEPTH, and the count SHALL range from 0 to BUF_DEPTH.
REQ-028 `redirect_pc` bits [1:0] SHALL be ignored (forced 0) when FETCH_ALIGN_CHK_EN is not defined.

Reset
REQ-029 On `rst_n`=0, asynchronously: PC SHALL be RESET_PC, count 0, pointers 0, state IDLE, `instr_valid`=0 and `fetch_trap`=0.
REQ-030 On `rst_n`=0, buffer contents need not be reset.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries; the first instruction after release SHALL be from RESET_PC.

Configuration
REQ-032 With FETCH_ALIGN_CHK_EN defined, a redirect whose `redirect_pc`[1:0]≠0 SHALL flush the buffer, leave PC unchanged, and enter TRAP.
REQ-033 In TRAP, `fetch_trap`=1, `instr_valid`=0 and no push SHALL occur.
REQ-034 TRAP SHALL be left only by an aligned redirect, which returns the FSM to FETCH with normal redirect behaviour; a misaligned redirect in TRAP SHALL stay in TRAP.
REQ-035 Without FETCH_ALIGN_CHK_EN, the TRAP state and the alignment logic SHALL be absent and `fetch_trap` SHALL be constant 0.

Verification
REQ-036 Sequential fetch: memory word k = 32'h1000_0000+k, RESET_PC=0, `instr_ready`=1 → from cycle 2 after release, `instr_out` = 32'h1000_0000, 32'h1000_0001, …, with `instr_pc` = 0, 4, 8, ….
REQ-037 Backpressure: `instr_ready`=0 for 5 cycles → count reaches BUF_DEPTH, PC stops at RESET_PC+4·BUF_DEPTH; on `instr_ready`=1 the entries drain in order with no loss or duplication.
REQ-038 Redirect with full buffer and `instr_ready`=1 in the same cycle: `redirect_pc`=32'h40 → no pop, `instr_valid`=0 the next cycle, then `instr_pc`=32'h40.
REQ-039 Wrap: redirect to 32'hFFFF_FFFC → `instr_pc` sequence FFFF_FFFC, 0000_0000, 0000_0004.
REQ-040 Reset mid-stream: `rst_n` pulsed low at an arbitrary point with 2 entries buffered → `instr_valid` drops immediately; after release the first `instr_pc` is RESET_PC.
REQ-041 (FETCH_ALIGN_CHK_EN) Redirect to 32'h42 → `fetch_trap`=1 and `instr_valid`=0 until a redirect to 32'h80; the next valid `instr_pc` is 32'h80.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, a small fetch buffer, redirect flush.
// Optional misaligned-redirect trap when FETCH_ALIGN_CHK_EN is defined.
module imem_fetch_ctrl #(
    parameter int                   word_size = 32,
    parameter logic [word_size-1:0] RESET_PC  = '0,
    parameter int                   BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [word_size-1:0] imem_addr,
    input  logic [word_size-1:0] imem_rd_instr,
    input  logic                 redirect_valid,
    input  logic [word_size-1:0] redirect_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [word_size-1:0] instr_out,
    output logic [word_size-1:0] instr_pc,
    output logic                 fetch_trap
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t DEPTH_C = cnt_t'(BUF_DEPTH);

    typedef struct packed {
        logic [word_size-1:0] instr;
        logic [word_size-1:0] pc;
    } entry_t;

`ifdef FETCH_ALIGN_CHK_EN
    typedef enum logic [1:0] {IDLE, FETCH, TRAP} state_t;
`else
    typedef enum logic {IDLE, FETCH} state_t;
`endif

    state_t               state_q, state_d;
    logic [word_size-1:0] pc_q, pc_d;
    cnt_t                 cnt_q, cnt_d;
    ptr_t                 rd_ptr_q, rd_ptr_d;
    ptr_t                 wr_ptr_q, wr_ptr_d;
    entry_t               fifo_q [BUF_DEPTH];
    logic                 push, pop;
    logic [word_size-1:0] tgt_pc;

`ifdef FETCH_ALIGN_CHK_EN
    logic misaligned;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign tgt_pc     = redirect_pc;
    assign fetch_trap = (state_q == TRAP);
`else
    assign tgt_pc     = redirect_pc & ~word_size'(3);
    assign fetch_trap = 1'b0;
`endif

    assign imem_addr   = pc_q;
    assign instr_valid = (cnt_q != '0);
    assign instr_out   = fifo_q[rd_ptr_q].instr;
    assign instr_pc    = fifo_q[rd_ptr_q].pc;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        push     = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    cnt_d    = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
`ifdef FETCH_ALIGN_CHK_EN
                    if (misaligned) state_d = TRAP;
                    else            pc_d    = tgt_pc;
`else
                    pc_d = tgt_pc;
`endif
                end else begin
                    pop  = instr_valid && instr_ready;
                    push = (cnt_q != DEPTH_C) || pop;
                end
            end
`ifdef FETCH_ALIGN_CHK_EN
            TRAP: begin
                // Buffer is already empty here; only an aligned target releases the trap.
                if (redirect_valid && !misaligned) begin
                    pc_d     = tgt_pc;
                    cnt_d    = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    state_d  = FETCH;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (push) begin
            pc_d     = pc_q + word_size'(4);
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
        if (push && !pop)      cnt_d = cnt_q + cnt_t'(1);
        else if (pop && !push) cnt_d = cnt_q - cnt_t'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{instr: imem_rd_instr, pc: pc_q};
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: memory word k = 32'h1000_0000 + k, expected PCs queued per scenario.
module tb_imem_fetch_ctrl;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fetch_trap;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    assign imem_rd_instr = 32'h1000_0000 + (imem_addr >> 2);

    imem_fetch_ctrl #(.word_size(32), .RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rd_instr(imem_rd_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc),
        .fetch_trap(fetch_trap)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // One cycle: drive inputs at the falling edge and score any transfer the next rising edge accepts.
    task automatic drive_cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [31:0] e;
        @(negedge clk);
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (instr_valid && rdy && !rv) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop_unexpected: got pc=%h instr=%h, required no output", instr_pc, instr_out);
            end else begin
                e = exp_q.pop_front();
                if (instr_pc !== e || instr_out !== mem_word(e))
                    $display("FAIL pop_data: got pc=%h instr=%h, required pc=%h instr=%h",
                             instr_pc, instr_out, e, mem_word(e));
                else pass_cnt++;
            end
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        total_cnt++;
        if (got !== want) $display("FAIL %s: got %b, required %b", name, got, want);
        else pass_cnt++;
    endtask

    task automatic check_drained(input string name);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL %s: %0d entries undelivered, required 0", name, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_bit("reset_valid", instr_valid, 1'b0);
        check_bit("reset_trap", fetch_trap, 1'b0);
        total_cnt++;
        if (imem_addr !== RPC) $display("FAIL reset_pc: got %h, required %h", imem_addr, RPC);
        else pass_cnt++;
    endtask

    task automatic test_sequential;
        for (int k = 0; k < 8; k++) exp_q.push_back(RPC + 32'(4 * k));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_cycle(1'b1, 1'b0, '0);
            check_bit($sformatf("seq_valid_%0d", i), instr_valid, (i >= 1));
        end
        check_drained("seq_drain");
    endtask

    task automatic test_backpressure;
        drive_cycle(1'b0, 1'b1, 32'h100);
        repeat (5) drive_cycle(1'b0, 1'b0, '0);
        total_cnt++;
        if (imem_addr !== 32'h100 + 32'(4 * DEPTH))
            $display("FAIL bp_pc_stall: got %h, required %h", imem_addr, 32'h100 + 32'(4 * DEPTH));
        else pass_cnt++;
        check_bit("bp_valid_full", instr_valid, 1'b1);
        for (int k = 0; k < 6; k++) exp_q.push_back(32'h100 + 32'(4 * k));
        repeat (6) drive_cycle(1'b1, 1'b0, '0);
        check_drained("bp_drain");
    endtask

    task automatic test_redirect_full;
        drive_cycle(1'b0, 1'b1, 32'h600);
        repeat (3) drive_cycle(1'b0, 1'b0, '0);
        check_bit("rf_full_valid", instr_valid, 1'b1);
        for (int k = 0; k < 3; k++) exp_q.push_back(32'h40 + 32'(4 * k));
        drive_cycle(1'b1, 1'b1, 32'h40);
        drive_cycle(1'b1, 1'b0, '0);
        check_bit("rf_flush_valid", instr_valid, 1'b0);
        repeat (3) drive_cycle(1'b1, 1'b0, '0);
        check_drained("rf_drain");
    endtask

    task automatic test_wrap;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        drive_cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        drive_cycle(1'b1, 1'b0, '0);
        check_bit("wrap_flush_valid", instr_valid, 1'b0);
        repeat (3) drive_cycle(1'b1, 1'b0, '0);
        check_drained("wrap_drain");
    endtask

    task automatic test_back_to_back;
        drive_cycle(1'b1, 1'b1, 32'h200);
        drive_cycle(1'b1, 1'b1, 32'h300);
        check_bit("b2b_mid_valid", instr_valid, 1'b0);
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        drive_cycle(1'b1, 1'b0, '0);
        check_bit("b2b_flush_valid", instr_valid, 1'b0);
        repeat (2) drive_cycle(1'b1, 1'b0, '0);
        check_drained("b2b_drain");
    endtask

    task automatic test_reset_mid;
        drive_cycle(1'b0, 1'b1, 32'h500);
        repeat (3) drive_cycle(1'b0, 1'b0, '0);
        check_bit("rm_buffered_valid", instr_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("rm_async_valid", instr_valid, 1'b0);
        total_cnt++;
        if (imem_addr !== RPC) $display("FAIL rm_async_pc: got %h, required %h", imem_addr, RPC);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) exp_q.push_back(RPC + 32'(4 * k));
        rst_n = 1'b1;
        drive_cycle(1'b1, 1'b0, '0);
        check_bit("rm_idle_valid", instr_valid, 1'b0);
        repeat (3) drive_cycle(1'b1, 1'b0, '0);
        check_drained("rm_drain");
    endtask

`ifdef FETCH_ALIGN_CHK_EN
    task automatic test_align_trap;
        drive_cycle(1'b1, 1'b1, 32'h42);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, '0);
            check_bit($sformatf("trap_flag_%0d", i), fetch_trap, 1'b1);
            check_bit($sformatf("trap_valid_%0d", i), instr_valid, 1'b0);
        end
        drive_cycle(1'b1, 1'b1, 32'h46);
        drive_cycle(1'b1, 1'b0, '0);
        check_bit("trap_stay", fetch_trap, 1'b1);
        exp_q.push_back(32'h80);
        exp_q.push_back(32'h84);
        drive_cycle(1'b1, 1'b1, 32'h80);
        drive_cycle(1'b1, 1'b0, '0);
        check_bit("trap_exit_flag", fetch_trap, 1'b0);
        check_bit("trap_exit_valid", instr_valid, 1'b0);
        repeat (2) drive_cycle(1'b1, 1'b0, '0);
        check_drained("trap_drain");
    endtask
`else
    task automatic test_align_ignore;
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        drive_cycle(1'b1, 1'b1, 32'h42);
        drive_cycle(1'b1, 1'b0, '0);
        check_bit("align_no_trap", fetch_trap, 1'b0);
        check_bit("align_flush_valid", instr_valid, 1'b0);
        repeat (2) drive_cycle(1'b1, 1'b0, '0);
        check_drained("align_drain");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_sequential;
        test_backpressure;
        test_redirect_full;
        test_wrap;
        test_back_to_back;
        test_reset_mid;
`ifdef FETCH_ALIGN_CHK_EN
        test_align_trap;
`else
        test_align_ignore;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
